// File: rtl/mac_secuencial_if.sv
// Bus bundle for mac_secuencial.
// The request side (master) raises start and supplies the sample and coefficient
// for the index that the MAC presents. The MAC side (slave) returns the index,
// the status flags and the frame result.
//   start    master->slave  frame request
//   x_in     master->slave  signed sample for idx (combinational fetch)
//   coef_in  master->slave  signed coefficient for idx
//   idx      slave->master  tap index being consumed
//   busy     slave->master  frame in progress (RUN or DONE)
//   done     slave->master  one-cycle result strobe
//   acc_out  slave->master  signed 2N-bit frame result
//   ovf      slave->master  frame overflow flag
interface mac_secuencial_if #(
  parameter int N  = 25,
  parameter int IW = 2
);
  logic                  start;
  logic signed [N-1:0]   x_in;
  logic signed [N-1:0]   coef_in;
  logic [IW-1:0]         idx;
  logic                  busy;
  logic                  done;
  logic signed [2*N-1:0] acc_out;
  logic                  ovf;

  modport master (
    output start, x_in, coef_in,
    input  idx, busy, done, acc_out, ovf
  );

  modport slave (
    input  start, x_in, coef_in,
    output idx, busy, done, acc_out, ovf
  );
endinterface

// File: rtl/mac_secuencial.sv
// Sequential signed multiply-accumulate.
// On start, steps idx over TAPS sample/coefficient pairs (one pair per clock).
// It accumulates the exact signed NxN products and publishes the 2N-bit sum on
// acc_out with a one-cycle done strobe. acc_out holds between frames.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mac_secuencial_if.slave (start, x_in, coef_in / idx, busy, done,
//          acc_out, ovf)
// Configuration macro MAC_SAT_EN: when defined, an overflowing step clamps the
// accumulator to the signed 2N-bit limit that matches the sign of the true sum.
// When undefined, the accumulator wraps modulo 2^(2N).
// ovf is reported in both builds.
module mac_secuencial #(
  parameter int N    = 25,
  parameter int TAPS = 4,
  parameter int IW   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  mac_secuencial_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic signed [2*N-1:0] acc_q, acc_d;
  logic signed [2*N-1:0] acc_out_q, acc_out_d;

  logic signed [2*N-1:0] prod;
  logic signed [2*N:0]   sum;
  logic                  sum_ovf;
  logic signed [2*N-1:0] step;

  // Reduce the one-bit-wider sum back to 2N bits, either by clamping or by wrapping.
  function automatic logic signed [2*N-1:0] fit_sum(input logic signed [2*N:0] s);
`ifdef MAC_SAT_EN
    if (s[2*N] != s[2*N-1])
      fit_sum = s[2*N] ? {1'b1, {(2*N-1){1'b0}}} : {1'b0, {(2*N-1){1'b1}}};
    else
      fit_sum = s[2*N-1:0];
`else
    fit_sum = s[2*N-1:0];
`endif
  endfunction

  // Exact product: both operands sign-extended to 2N bits before multiplying.
  assign prod = $signed({{N{bus.x_in[N-1]}}, bus.x_in}) *
                $signed({{N{bus.coef_in[N-1]}}, bus.coef_in});

  // One guard bit makes overflow visible as a mismatch of the two top bits.
  assign sum     = $signed({acc_q[2*N-1], acc_q}) + $signed({prod[2*N-1], prod});
  assign sum_ovf = sum[2*N] ^ sum[2*N-1];
  assign step    = fit_sum(sum);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          acc_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        acc_d = step;
        ovf_d = ovf_q | sum_ovf;
        idx_d = idx_q + 1'b1;
        // acc_out and done are registered together so the result is already
        // present during the done cycle.
        if (idx_q == IW'(TAPS - 1)) begin
          state_d   = DONE;
          done_d    = 1'b1;
          acc_out_d = step;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      acc_out_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
    end
  end

  assign bus.idx     = idx_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.acc_out = acc_out_q;
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_mac_secuencial.sv
module tb_mac_secuencial;
  localparam int N = 25;
  localparam int TAPS = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  logic signed [N-1:0] xv [TAPS];
  logic signed [N-1:0] cv [TAPS];

  mac_secuencial_if #(.N(N), .IW(IW)) mif ();

  mac_secuencial #(.N(N), .TAPS(TAPS), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  always #5 clk = ~clk;

  // Combinational sample/coefficient source indexed by the DUT.
  assign mif.x_in    = xv[mif.idx];
  assign mif.coef_in = cv[mif.idx];

  task automatic load(input int x0, x1, x2, x3, c0, c1, c2, c3);
    xv[0] = N'(x0); xv[1] = N'(x1); xv[2] = N'(x2); xv[3] = N'(x3);
    cv[0] = N'(c0); cv[1] = N'(c1); cv[2] = N'(c2); cv[3] = N'(c3);
  endtask

  // One start pulse, then the idx sequence, the done cycle, the result and the return to idle are checked.
  task automatic frame(input string name, input logic signed [2*N-1:0] exp_acc,
                       input logic exp_ovf);
    int cyc;
    bit seen;
    logic signed [2*N-1:0] held;
    @(negedge clk); mif.start = 1'b1;
    @(negedge clk); mif.start = 1'b0;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (mif.done) seen = 1'b1;
      else begin
        if (cyc <= TAPS) begin
          vectors++;
          if (mif.idx !== IW'(cyc - 1)) begin
            miscompares++;
            $display("FAIL %s idx cycle %0d: got %0d expected %0d", name, cyc, mif.idx, cyc - 1);
          end
        end
        @(negedge clk); cyc++;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s done timeout: got none expected cycle %0d", name, TAPS + 1);
    end else if (cyc != TAPS + 1) begin
      miscompares++;
      $display("FAIL %s done cycle: got %0d expected %0d", name, cyc, TAPS + 1);
    end
    vectors++;
    if (mif.acc_out !== exp_acc) begin
      miscompares++;
      $display("FAIL %s acc_out: got %0d expected %0d", name, mif.acc_out, exp_acc);
    end
    vectors++;
    if (mif.ovf !== exp_ovf) begin
      miscompares++;
      $display("FAIL %s ovf: got %0b expected %0b", name, mif.ovf, exp_ovf);
    end
    held = mif.acc_out;
    @(negedge clk);
    vectors++;
    if (mif.done !== 1'b0 || mif.busy !== 1'b0 || mif.acc_out !== held) begin
      miscompares++;
      $display("FAIL %s after done: done=%0b busy=%0b acc=%0d expected 0 0 %0d",
               name, mif.done, mif.busy, mif.acc_out, held);
    end
  endtask

  task automatic test_reset();
    mif.start = 1'b0;
    load(1, 2, 3, 4, 1, 1, 1, 1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (mif.idx !== '0 || mif.busy !== 1'b0 || mif.done !== 1'b0 ||
        mif.acc_out !== '0 || mif.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: idx=%0d busy=%0b done=%0b acc=%0d ovf=%0b expected all 0",
               mif.idx, mif.busy, mif.done, mif.acc_out, mif.ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (mif.busy !== 1'b0 || mif.acc_out !== '0) begin
      miscompares++;
      $display("FAIL reset release: busy=%0b acc=%0d expected 0 0", mif.busy, mif.acc_out);
    end
  endtask

  task automatic test_basic();
    load(1, 2, 3, 4, 1, 1, 1, 1);
    frame("basic", 50'sd10, 1'b0);
  endtask

  task automatic test_signed();
    load(-3, 5, -7, 2, 4, -2, 1, -8);
    frame("signed", -50'sd45, 1'b0);
  endtask

  task automatic test_overflow();
    load(16777215, 16777215, 16777215, 16777215, 16777215, 16777215, 16777215, 16777215);
`ifdef MAC_SAT_EN
    frame("overflow", 50'sd562949953421311, 1'b1);
`else
    frame("overflow", -50'sd134217724, 1'b1);
`endif
  endtask

  task automatic test_ignore_start();
    int dones;
    int dcyc;
    logic signed [2*N-1:0] prev;
    load(1, 2, 3, 4, 1, 1, 1, 1);
    prev = mif.acc_out;
    dones = 0; dcyc = 0;
    @(negedge clk); mif.start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      mif.start = (c == 2 || c == TAPS + 1);
      if (mif.done) begin dones++; dcyc = c; end
      vectors++;
      if (mif.acc_out !== ((c < TAPS + 1) ? prev : 50'sd10)) begin
        miscompares++;
        $display("FAIL ignore acc_out cycle %0d: got %0d expected %0d", c, mif.acc_out,
                 (c < TAPS + 1) ? prev : 50'sd10);
      end
    end
    mif.start = 1'b0;
    vectors++;
    if (dones != 1 || dcyc != TAPS + 1) begin
      miscompares++;
      $display("FAIL ignore done count: got %0d at cycle %0d expected 1 at cycle %0d",
               dones, dcyc, TAPS + 1);
    end
    vectors++;
    if (mif.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore ovf clear: got %0b expected 0", mif.ovf);
    end
  endtask

  task automatic test_abort();
    int dones;
    load(5, 5, 5, 5, 3, 3, 3, 3);
    @(negedge clk); mif.start = 1'b1;
    @(negedge clk); mif.start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (mif.idx !== 2'd2) begin
      miscompares++;
      $display("FAIL abort setup idx: got %0d expected 2", mif.idx);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (mif.idx !== '0 || mif.busy !== 1'b0 || mif.done !== 1'b0 ||
        mif.acc_out !== '0 || mif.ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: idx=%0d busy=%0b done=%0b acc=%0d ovf=%0b expected all 0",
               mif.idx, mif.busy, mif.done, mif.acc_out, mif.ovf);
    end
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (mif.done) dones++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (mif.done) dones++;
    end
    vectors++;
    if (dones != 0 || mif.acc_out !== '0) begin
      miscompares++;
      $display("FAIL abort no done: got %0d dones acc=%0d expected 0 0", dones, mif.acc_out);
    end
    load(1, 2, 3, 4, 1, 1, 1, 1);
    frame("abort restart", 50'sd10, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic signed [2*N-1:0] exp [3];
    int dcyc [3];
    int nd;
    exp[0] = 50'sd10; exp[1] = -50'sd45; exp[2] = 50'sd200;
    dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
    nd = 0;
    load(1, 2, 3, 4, 1, 1, 1, 1);
    @(negedge clk); mif.start = 1'b1;
    for (int c = 1; c <= 3 * (TAPS + 2) + 2 && nd < 3; c++) begin
      @(negedge clk);
      if (mif.done) begin
        dcyc[nd] = c;
        vectors++;
        if (mif.acc_out !== exp[nd]) begin
          miscompares++;
          $display("FAIL b2b frame %0d acc_out: got %0d expected %0d", nd, mif.acc_out, exp[nd]);
        end
        nd++;
        if (nd == 1) load(-3, 5, -7, 2, 4, -2, 1, -8);
        if (nd == 2) load(100, -200, 300, -400, -1, -1, -1, -1);
        if (nd == 3) mif.start = 1'b0;
      end
    end
    mif.start = 1'b0;
    vectors++;
    if (nd != 3) begin
      miscompares++;
      $display("FAIL b2b done count: got %0d expected 3", nd);
    end
    for (int f = 0; f < 3; f++) begin
      vectors++;
      if (dcyc[f] != (f + 1) * (TAPS + 2) - 1) begin
        miscompares++;
        $display("FAIL b2b frame %0d done cycle: got %0d expected %0d", f, dcyc[f],
                 (f + 1) * (TAPS + 2) - 1);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
    $fatal(1);
  end

endmodule
